// File: rtl/spike_wave_scheduler_pkg.sv
// Shared types, constants and the spike-time to shift-code conversion
// used by the spike wave scheduler and its banks.
package spike_sched_pkg;

  localparam int CODE_W = 8;
  localparam int MAX_SPIKE_TIME = 8;
  localparam logic [CODE_W-1:0] NO_SPIKE_CODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              clip;
  } code_clip_t;

  // Earlier spikes map to wider masks; anything past the last slot is
  // treated as no spike and flagged so the source can be fixed upstream.
  function automatic code_clip_t time_to_code(input logic [31:0] t);
    code_clip_t r;
    if (t > 32'(MAX_SPIKE_TIME)) begin
      r.code = NO_SPIKE_CODE;
      r.clip = 1'b1;
    end else begin
      r.code = {CODE_W{1'b1}} >> t[3:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_wave_scheduler_if.sv
// Spike-time input stream and encoder-row output bundle.
interface spike_wave_scheduler_if
  import spike_sched_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TIME_W    = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [TIME_W-1:0]           in_time;
  logic                        in_last;
  logic                        enc_valid;
  logic [NUM_LANES*CODE_W-1:0] enc_value;
  logic                        wave_active;
  logic                        wave_done;
  logic [15:0]                 wave_count;
  logic                        clip_err;

  modport master (
    output in_valid, in_time, in_last,
    input  in_ready, enc_valid, enc_value, wave_active, wave_done,
           wave_count, clip_err
  );

  modport slave (
    input  in_valid, in_time, in_last,
    output in_ready, enc_valid, enc_value, wave_active, wave_done,
           wave_count, clip_err
  );

endinterface

// File: rtl/spike_wave_bank.sv
// One wave's worth of per-lane codes: lane-indexed write, whole-bank
// clear back to no-spike, and all lanes readable in parallel.
module spike_wave_bank
  import spike_sched_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [LANE_W-1:0]           wr_lane,
  input  logic [CODE_W-1:0]           wr_code,
  input  logic                        clr,
  output logic [NUM_LANES*CODE_W-1:0] rd_data
);

  logic [NUM_LANES-1:0][CODE_W-1:0] data_q;
  logic [NUM_LANES-1:0][CODE_W-1:0] data_d;

  // Clear wins over write; the scheduler never does both to one bank.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      for (int i = 0; i < NUM_LANES; i++) data_d[i] = NO_SPIKE_CODE;
    end else if (wr_en) begin
      data_d[wr_lane] = wr_code;
    end
  end

  // Bank storage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) data_q[i] <= NO_SPIKE_CODE;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/spike_wave_scheduler.sv
// Collects one spike time per lane into a ping-pong bank pair and plays
// each completed bank to the encoder row as a single load pulse followed
// by a fixed-length wave.
//
// state | meaning
// IDLE  | no wave running, waiting for the read bank to fill
// LOAD  | one-cycle load pulse, read bank driven onto enc_value
// RUN   | wave in progress, run_cnt counting down to the final cycle
module spike_wave_scheduler
  import spike_sched_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int WAVE_CYCLES = 9,
  parameter int TIME_W      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  spike_wave_scheduler_if.slave  bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int RUN_W  = (WAVE_CYCLES > 1) ? $clog2(WAVE_CYCLES) : 1;
  localparam int VAL_W  = NUM_LANES * CODE_W;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic               enc_valid_q, enc_valid_d;
  logic [VAL_W-1:0]   enc_value_q, enc_value_d;
  logic               wave_done_q, wave_done_d;
  logic               wave_active_q, wave_active_d;
  logic [15:0]        wave_count_q, wave_count_d;

  logic               wr_bank_q, wr_bank_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [1:0]         full_q, full_d;
  logic               clip_q, clip_d;

  logic [TIME_W-1:0]  in_time_w;
  code_clip_t         conv;
  logic               in_ready;
  logic               hs;
  logic               batch_end;
  logic               wave_end;
  logic [1:0]         bank_wr;
  logic [1:0]         bank_clr;
  logic [VAL_W-1:0]   bank_rd [2];

  assign in_time_w = bus.in_time;
  assign conv      = time_to_code(32'(in_time_w));
  assign in_ready  = !full_q[wr_bank_q];
  assign hs        = bus.in_valid && in_ready;
  assign batch_end = hs && (bus.in_last || (lane_q == LANE_W'(NUM_LANES - 1)));
  assign wave_end  = (state_q == RUN) && (run_cnt_q == '0);

  // A write only ever targets wr_bank, which is never the bank being played
  // while it is full, so reads and writes cannot collide.
  assign bank_wr  = {hs & wr_bank_q, hs & ~wr_bank_q};
  assign bank_clr = {wave_end & rd_bank_q, wave_end & ~rd_bank_q};

  spike_wave_bank #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_bank0 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bank_wr[0]),
    .wr_lane (lane_q),
    .wr_code (conv.code),
    .clr     (bank_clr[0]),
    .rd_data (bank_rd[0])
  );

  spike_wave_bank #(.NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) u_bank1 (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (bank_wr[1]),
    .wr_lane (lane_q),
    .wr_code (conv.code),
    .clr     (bank_clr[1]),
    .rd_data (bank_rd[1])
  );

  // Collect side: advance lane, close out a batch and swap write bank.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    lane_d    = lane_q;
    clip_d    = clip_q | (hs & conv.clip);
    if (wave_end) full_d[rd_bank_q] = 1'b0;
    if (batch_end) begin
      full_d[wr_bank_q] = 1'b1;
      lane_d            = '0;
      wr_bank_d         = ~wr_bank_q;
    end else if (hs) begin
      lane_d = lane_q + LANE_W'(1);
    end
  end

  // Collect-side registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      lane_q    <= '0;
      clip_q    <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      lane_q    <= lane_d;
      clip_q    <= clip_d;
    end
  end

  // Schedule FSM next state; outputs are derived from the next state so
  // they come straight out of flops in the cycle the state is entered.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    rd_bank_d    = rd_bank_q;
    wave_count_d = wave_count_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = LOAD;
      end
      LOAD: begin
        run_cnt_d = RUN_W'(WAVE_CYCLES - 1);
        state_d   = RUN;
      end
      RUN: begin
        if (run_cnt_q == '0) begin
          wave_count_d = wave_count_q + 16'd1;
          rd_bank_d    = ~rd_bank_q;
          state_d      = full_q[~rd_bank_q] ? LOAD : IDLE;
        end else begin
          run_cnt_d = run_cnt_q - RUN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    enc_valid_d   = (state_d == LOAD);
    enc_value_d   = enc_valid_d ? bank_rd[rd_bank_d] : '0;
    wave_done_d   = (state_d == RUN) && (run_cnt_d == '0);
    wave_active_d = (state_d != IDLE);
  end

  // Schedule FSM state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      run_cnt_q     <= '0;
      rd_bank_q     <= 1'b0;
      enc_valid_q   <= 1'b0;
      enc_value_q   <= '0;
      wave_done_q   <= 1'b0;
      wave_active_q <= 1'b0;
      wave_count_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      rd_bank_q     <= rd_bank_d;
      enc_valid_q   <= enc_valid_d;
      enc_value_q   <= enc_value_d;
      wave_done_q   <= wave_done_d;
      wave_active_q <= wave_active_d;
      wave_count_q  <= wave_count_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.enc_valid   = enc_valid_q;
  assign bus.enc_value   = enc_value_q;
  assign bus.wave_done   = wave_done_q;
  assign bus.wave_active = wave_active_q;
  assign bus.wave_count  = wave_count_q;
  assign bus.clip_err    = clip_q;

endmodule

// File: tb/tb_spike_wave_scheduler.sv
// Scoreboard bench for spike_wave_scheduler: batches push their expected
// lane codes, a negedge monitor pops and checks each load and wave end.
module tb_spike_wave_scheduler;

  localparam int NUM_LANES   = 4;
  localparam int WAVE_CYCLES = 9;
  localparam int TIME_W      = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spike_wave_scheduler_if #(.NUM_LANES(NUM_LANES), .TIME_W(TIME_W)) bus ();

  spike_wave_scheduler #(
    .NUM_LANES   (NUM_LANES),
    .WAVE_CYCLES (WAVE_CYCLES),
    .TIME_W      (TIME_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] exp_q [$];
  int sub_cnt = 0;
  int done_cnt = 0;
  int load_cyc [16];
  int done_cyc [16];
  int nload = 0;
  int ndone = 0;
  int last_load = 0;
  bit cnt_pending = 0;
  int hs_final_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every load against the scoreboard, time each wave end.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        done_cnt    = 0;
        nload       = 0;
        ndone       = 0;
        cnt_pending = 0;
      end else begin
        chk("in_ready", 32'(bus.in_ready), 32'((sub_cnt - done_cnt) < 2));
        if (cnt_pending) begin
          chk("wave_count", 32'(bus.wave_count), 32'(done_cnt));
          cnt_pending = 0;
        end
        if (bus.enc_valid) begin
          chk("wave_active_load", 32'(bus.wave_active), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL enc_unexpected: got %h expected no load", bus.enc_value);
          end else begin
            chk("enc_value", bus.enc_value, exp_q.pop_front());
          end
          if (nload < 16) load_cyc[nload] = cyc;
          nload++;
          last_load = cyc;
        end else begin
          chk("enc_value_idle", bus.enc_value, 32'd0);
        end
        if (bus.wave_done) begin
          chk("done_latency", 32'(cyc - last_load), 32'(WAVE_CYCLES));
          if (ndone < 16) done_cyc[ndone] = cyc;
          ndone++;
          done_cnt++;
          cnt_pending = 1;
        end
      end
    end
  end

  task automatic send_word(input logic [3:0] t, input logic last, output int hs);
    int budget;
    bit rdy;
    budget = 200;
    rdy = 0;
    hs = 0;
    bus.in_valid = 1'b1;
    bus.in_time  = t;
    bus.in_last  = last;
    while (!rdy && budget > 0) begin
      @(negedge clock);
      rdy = bus.in_ready;
      hs  = cyc;
      @(posedge clock);
      #1;
      budget--;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic send_batch(input logic [3:0] t [4], input int n, input logic [31:0] exp);
    int hs;
    exp_q.push_back(exp);
    for (int i = 0; i < n; i++) begin
      send_word(t[i], (i == n - 1), hs);
    end
    sub_cnt++;
    hs_final_cyc = hs;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_time  = '0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 400;
    while ((exp_q.size() != 0 || done_cnt != sub_cnt) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending loads %0d, waves done %0d of %0d", exp_q.size(), done_cnt, sub_cnt);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete();
    sub_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enc_valid"},   32'(bus.enc_valid),   32'd0);
    chk({tag, "_enc_value"},   bus.enc_value,        32'd0);
    chk({tag, "_wave_done"},   32'(bus.wave_done),   32'd0);
    chk({tag, "_wave_active"}, 32'(bus.wave_active), 32'd0);
    chk({tag, "_wave_count"},  32'(bus.wave_count),  32'd0);
    chk({tag, "_clip_err"},    32'(bus.clip_err),    32'd0);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2 reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("por");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic wave: times 0,3,8,1
    send_batch('{4'd0, 4'd3, 4'd8, 4'd1}, 4, 32'h7F001FFF);
    idle_inputs();
    wait_idle();
    @(negedge clock);
    chk("t1_wave_count", 32'(bus.wave_count), 32'd1);
    chk("t1_load_latency", 32'(load_cyc[0] - hs_final_cyc), 32'd2);

    // Two batches streamed back to back
    @(posedge clock); #1;
    do_reset();
    send_batch('{4'd0, 4'd1, 4'd2, 4'd3}, 4, 32'h1F3F7FFF);
    send_batch('{4'd4, 4'd5, 4'd6, 4'd7}, 4, 32'h0103070F);
    idle_inputs();
    wait_idle();
    @(negedge clock);
    chk("t2_wave_count", 32'(bus.wave_count), 32'd2);
    chk("t2_back_to_back", 32'(load_cyc[1] - done_cyc[0]), 32'd1);

    // Short batches ended by in_last
    @(posedge clock); #1;
    do_reset();
    send_batch('{4'd2, 4'd5, 4'd0, 4'd0}, 2, 32'h0000073F);
    send_batch('{4'd1, 4'd0, 4'd0, 4'd0}, 1, 32'h0000007F);
    idle_inputs();
    wait_idle();

    // Out-of-range times clip to no-spike and latch clip_err
    @(posedge clock); #1;
    chk("t4_clip_before", 32'(bus.clip_err), 32'd0);
    send_batch('{4'd12, 4'd4, 4'd15, 4'd8}, 4, 32'h00000F00);
    chk("t4_clip_set", 32'(bus.clip_err), 32'd1);
    send_batch('{4'd0, 4'd1, 4'd2, 4'd3}, 4, 32'h1F3F7FFF);
    idle_inputs();
    wait_idle();
    chk("t4_clip_sticky", 32'(bus.clip_err), 32'd1);

    // Three batches held valid through a full-bank stall
    @(posedge clock); #1;
    do_reset();
    send_batch('{4'd8, 4'd7, 4'd6, 4'd5}, 4, 32'h07030100);
    send_batch('{4'd4, 4'd3, 4'd2, 4'd1}, 4, 32'h7F3F1F0F);
    send_batch('{4'd0, 4'd2, 4'd4, 4'd6}, 4, 32'h030F3FFF);
    idle_inputs();
    wait_idle();
    @(negedge clock);
    chk("t5_wave_count", 32'(bus.wave_count), 32'd3);
    chk("t5_back_to_back", 32'(load_cyc[2] - done_cyc[1]), 32'd1);

    // Reset while running with the second bank full
    @(posedge clock); #1;
    do_reset();
    send_batch('{4'd9, 4'd0, 4'd0, 4'd0}, 4, 32'hFFFFFF00);
    send_batch('{4'd1, 4'd1, 4'd1, 4'd1}, 4, 32'h7F7F7F7F);
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("t6_active_pre", 32'(bus.wave_active), 32'd1);
    chk("t6_clip_pre", 32'(bus.clip_err), 32'd1);
    #2 reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("t6");
    @(posedge clock); #1;
    exp_q.delete();
    sub_cnt = 0;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    send_batch('{4'd3, 4'd2, 4'd1, 4'd0}, 4, 32'hFF7F3F1F);
    idle_inputs();
    wait_idle();
    @(negedge clock);
    chk("t6_wave_count", 32'(bus.wave_count), 32'd1);
    chk("t6_loads", 32'(nload), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
